// File: rtl/job_phase_sequencer.sv
// ============================================================================
//  Module   : job_phase_sequencer
//  Purpose  : Walks a job through up to NPH phase engines with a watchdog,
//             optional settle gaps, bypass, abort and auto re-arm.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module job_phase_sequencer #(
    parameter int NPH    = 4,
    parameter int SETTLE = 1,
    parameter int TMO_W  = 24,
    parameter int JCNT_W = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n2,
    input  logic                     go,
    input  logic                     auto_run,
    input  logic                     abort,
    input  logic [NPH-1:0]           bypass,
    input  logic [NPH-1:0]           ph_end,
    output logic [NPH-1:0]           ph_start,
    output logic [$clog2(NPH)-1:0]   ph_sel,
    output logic                     ram_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(NPH)-1:0]   err_phase,
    output logic [JCNT_W-1:0]        job_cnt
);

    localparam int SEL_W = $clog2(NPH);
    localparam logic [TMO_W-1:0] C_WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_FIN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [TMO_W-1:0]    wdog_q, wdog_d;
    logic [3:0]          scnt_q, scnt_d;
    logic [NPH-1:0]      ph_start_q, ph_start_d;
    logic [SEL_W-1:0]    ph_sel_q, ph_sel_d;
    logic                ram_en_q, ram_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    err_phase_q, err_phase_d;
    logic [JCNT_W-1:0]   job_cnt_q, job_cnt_d;

    int                  nxt_lo;
    logic                nxt_found;
    logic [SEL_W-1:0]    nxt_idx;
    logic                advance;

    // Lowest non-bypassed phase at or above nxt_lo; bypass is read live.
    always_comb begin
        nxt_lo    = (state_q == S_ARM) ? 0 : int'(ph_sel_q) + 1;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NPH - 1; i >= 0; i--) begin
            if (i >= nxt_lo && !bypass[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        scnt_d      = scnt_q;
        ph_start_d  = ph_start_q;
        ph_sel_d    = ph_sel_q;
        ram_en_d    = ram_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_phase_d = err_phase_q;
        job_cnt_d   = job_cnt_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_ARM;
                    ram_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_ARM: begin
                if (!abort) advance = 1'b1;
            end
            S_RUN: begin
                if (abort) begin
                    // handled below with the common abort path
                end else if (ph_end[ph_sel_q]) begin
                    ph_start_d = '0;
                    if (SETTLE > 0) begin
                        state_d = S_SETTLE;
                        scnt_d  = 4'(SETTLE - 1);
                    end else begin
                        advance = 1'b1;
                    end
                end else if (wdog_q == C_WDOG_LAST) begin
                    // The increment about to happen reaches the terminal count.
                    state_d     = S_ERR;
                    err_d       = 1'b1;
                    err_phase_d = ph_sel_q;
                    ph_start_d  = '0;
                    ram_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    wdog_d      = '0;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                end
            end
            S_SETTLE: begin
                if (!abort) begin
                    if (scnt_q == 4'd0) advance = 1'b1;
                    else                scnt_d  = scnt_q - 4'd1;
                end
            end
            S_FIN: begin
                if (!abort && auto_run) begin
                    state_d  = S_ARM;
                    ram_en_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (go) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (nxt_found) begin
                state_d    = S_RUN;
                ph_sel_d   = nxt_idx;
                ph_start_d = NPH'(1) << nxt_idx;
                wdog_d     = '0;
            end else begin
                state_d    = S_FIN;
                ph_start_d = '0;
                ram_en_d   = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                job_cnt_d  = job_cnt_q + JCNT_W'(1);
            end
        end

        if (abort && state_q != S_IDLE && state_q != S_ERR) begin
            state_d    = S_IDLE;
            ph_start_d = '0;
            ram_en_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            job_cnt_d  = job_cnt_q;
            wdog_d     = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n2) begin
        if (sys_rst_n2) begin
            state_q     <= S_IDLE;
            wdog_q      <= '0;
            scnt_q      <= '0;
            ph_start_q  <= '0;
            ph_sel_q    <= '0;
            ram_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_phase_q <= '0;
            job_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            scnt_q      <= scnt_d;
            ph_start_q  <= ph_start_d;
            ph_sel_q    <= ph_sel_d;
            ram_en_q    <= ram_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_phase_q <= err_phase_d;
            job_cnt_q   <= job_cnt_d;
        end
    end

    assign ph_start  = ph_start_q;
    assign ph_sel    = ph_sel_q;
    assign ram_en    = ram_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_phase = err_phase_q;
    assign job_cnt   = job_cnt_q;

endmodule

`default_nettype wire
